alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
// ID/EX pipeline register plus EX-side operand selection directly upstream of the ALU.
// - Registers the decoded instruction fields.
// - Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
// - Detects load-use hazards and inserts bubbles.
// - Drives the ALU Data1/Data2/Control inputs and passes destination info down the pipe.
// PARAMETERS
// WIDTH    32  datapath width (operands, immediate, results)
// REG_AW   5   register-file address width
// CTRL_W   4   ALU control code width (codes 0000 and,0001 or,0010 add,0110 sub,0111 slt,1100 nor,1101 xor,1110 dif)
// PORTS
// Clock         in   1       single clock; all state updates on rising edge
// Reset         in   1       synchronous, active-high
// Stall         in   1       downstream hold: freeze all stage registers
// Flush         in   1       branch/jump squash: load a bubble
// InValid       in   1       ID-side instruction valid
// RsData        in   WIDTH   register-file read of Rs
// RtData        in   WIDTH   register-file read of Rt
// Imm           in   WIDTH   sign/zero-extended immediate from decode
// UseImm        in   1       1: Data2 = immediate, 0: Data2 = Rt operand
// AluOp         in   CTRL_W  ALU control code from ALU-control decode
// Rs, Rt, Rd    in   REG_AW  source/destination register numbers (Rd already muxed for I-type)
// RegWrite      in   1       instruction writes a register
// MemRead       in   1       instruction is a load
// ExMemRegWrite in   1       EX/MEM stage writes a register
// ExMemRd       in   REG_AW  EX/MEM destination
// ExMemResult   in   WIDTH   EX/MEM ALU result
// MemWbRegWrite in   1       MEM/WB stage writes a register
// MemWbRd       in   REG_AW  MEM/WB destination
// MemWbResult   in   WIDTH   MEM/WB writeback value
// Data1         out  WIDTH   ALU operand 1 (forwarded Rs)
// Data2         out  WIDTH   ALU operand 2 (immediate or forwarded Rt)
// Control       out  CTRL_W  registered AluOp
// StoreData     out  WIDTH   forwarded Rt, for stores
// ExRd          out  REG_AW  registered destination
// ExRegWrite    out  1       registered RegWrite gated by ExValid
// ExMemRead     out  1       registered MemRead gated by ExValid
// ExValid       out  1       stage holds a real instruction
// HazardStall   out  1       load-use detected: upstream must hold PC and IF/ID
// BEHAVIOUR
// - Reset: all registers 0; ExValid/ExRegWrite/ExMemRead/HazardStall 0; Control 0000; Data1/Data2/StoreData 0.
// - Register update priority: Reset > Flush (bubble) > Stall (hold) > HazardStall (bubble) > load ID fields.
// - Bubble: ExValid, RegWrite, MemRead cleared; other fields don't-care but forced 0.
// - Latency: one cycle from ID inputs to Control/Data outputs. Forwarding muxes are combinational on registered Rs/Rt.
// - Forwarding for src in {Rs_q, Rt_q}:
//   - src==0: use the registered regfile value (r0 never forwarded).
//   - Else if ExMemRegWrite && ExMemRd==src: use ExMemResult (EX/MEM wins over MEM/WB).
//   - Else if MemWbRegWrite && MemWbRd==src: use MemWbResult.
//   - Else: use the registered RsData/RtData.
// - Data2 = UseImm_q ? Imm_q : fwdRt. StoreData = fwdRt always.
// - HazardStall (combinational) = ExValid & MemRead_q & Rt_q!=0 & InValid & (Rt_q==Rs | Rt_q==Rt).
//   - Asserted for exactly one cycle per load-use pair; next cycle the load sits in MEM, so MEM/WB forwarding covers it.
// - Stall and HazardStall together: Stall wins; the register holds and HazardStall stays asserted.
// - Flush overrides HazardStall; HazardStall deasserts the cycle after Flush because ExValid=0.
// - Arithmetic: none; all paths are WIDTH-bit selection, no truncation or extension.
// TESTING
// 1 Reset held 2 cycles, inputs toggling -> ExValid=0, Control=0000, Data1=Data2=0; after release, first valid op appears next cycle.
// 2 add r3,r1,r2 (RsData=5, RtData=7, AluOp=0010), no forwarding -> next cycle Data1=5, Data2=7, Control=0010, ExRd=3.
// 3 ExMemRd=MemWbRd=1 (both writing), ExMemResult=0xAA, MemWbResult=0xBB, Rs_q=1 -> Data1=0xAA; with ExMemRegWrite=0 -> Data1=0xBB; Rs_q=0 -> Data1=RsData_q.
// 4 lw r4 in stage, next ID uses Rs=4 -> HazardStall=1 for one cycle, bubble (ExValid=0) enters, then consumer loads with MemWb forwarding of r4.
// 5 Stall=1 for 3 cycles with new ID inputs -> all outputs frozen; Flush=1 with Stall=1 -> ExValid=0 next cycle.
// 6 UseImm=1, Imm=0xFFFFFFFC, Rt forwarded 0x10 -> Data2=0xFFFFFFFC, StoreData=0x10.

Source files
------------

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// ID/EX pipeline register plus the EX-side operand selection that feeds the
// ALU. Decoded instruction fields are captured on the rising edge. Operands
// are then resolved combinationally from the registered fields and the
// current EX/MEM and MEM/WB writeback buses. A load followed by a dependent
// instruction holds the upstream stages for one cycle and inserts a bubble.
//
// Ports
//   Clock, Reset        single clock, synchronous active-high reset
//   Stall               downstream hold: all stage registers keep their value
//   Flush               squash: load a bubble
//   InValid             ID-side instruction valid
//   RsData/RtData/Imm   ID-side operand values
//   UseImm, AluOp       operand-2 select and ALU control code
//   Rs/Rt/Rd            source and destination register numbers
//   RegWrite/MemRead    ID-side write-back and load flags
//   ExMem*/MemWb*       forwarding sources from the two later stages
//   Data1/Data2         ALU operands
//   Control             registered ALU control code
//   StoreData           forwarded Rt, used by stores
//   ExRd/ExRegWrite/ExMemRead/ExValid  destination info passed down the pipe
//   HazardStall         load-use detected: upstream holds PC and IF/ID
// ---------------------------------------------------------------------------
module alu_operand_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              InValid,
  input  logic [WIDTH-1:0]  RsData,
  input  logic [WIDTH-1:0]  RtData,
  input  logic [WIDTH-1:0]  Imm,
  input  logic              UseImm,
  input  logic [CTRL_W-1:0] AluOp,
  input  logic [REG_AW-1:0] Rs,
  input  logic [REG_AW-1:0] Rt,
  input  logic [REG_AW-1:0] Rd,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              ExMemRegWrite,
  input  logic [REG_AW-1:0] ExMemRd,
  input  logic [WIDTH-1:0]  ExMemResult,
  input  logic              MemWbRegWrite,
  input  logic [REG_AW-1:0] MemWbRd,
  input  logic [WIDTH-1:0]  MemWbResult,
  output logic [WIDTH-1:0]  Data1,
  output logic [WIDTH-1:0]  Data2,
  output logic [CTRL_W-1:0] Control,
  output logic [WIDTH-1:0]  StoreData,
  output logic [REG_AW-1:0] ExRd,
  output logic              ExRegWrite,
  output logic              ExMemRead,
  output logic              ExValid,
  output logic              HazardStall
);

  logic              vld_p1;
  logic              regwrite_p1;
  logic              memread_p1;
  logic              useimm_p1;
  logic [CTRL_W-1:0] aluop_p1;
  logic [REG_AW-1:0] rs_p1;
  logic [REG_AW-1:0] rt_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [WIDTH-1:0]  rsdata_p1;
  logic [WIDTH-1:0]  rtdata_p1;
  logic [WIDTH-1:0]  imm_p1;

  logic [WIDTH-1:0]  fwd_rs;
  logic [WIDTH-1:0]  fwd_rt;

  // Operand source selection. r0 is hard-wired zero in the register file,
  // so a writer targeting r0 must never be forwarded. The younger producer
  // (EX/MEM) holds the most recent value and therefore wins.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic [WIDTH-1:0]  regval,
    input logic              em_we,
    input logic [REG_AW-1:0] em_rd,
    input logic [WIDTH-1:0]  em_res,
    input logic              mw_we,
    input logic [REG_AW-1:0] mw_rd,
    input logic [WIDTH-1:0]  mw_res
  );
    logic [WIDTH-1:0] val;
    val = regval;
    if (src != '0) begin
      if (em_we && (em_rd == src))
        val = em_res;
      else if (mw_we && (mw_rd == src))
        val = mw_res;
    end
    return val;
  endfunction

  // Load-use: the load in EX only has its data in MEM/WB two cycles later,
  // so a dependent instruction in ID must wait exactly one cycle.
  assign HazardStall = vld_p1 && memread_p1 && (rt_p1 != '0) && InValid &&
                       ((rt_p1 == Rs) || (rt_p1 == Rt));

  // ---- ID -> EX boundary (p1) ----
  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      vld_p1      <= 1'b0;
      regwrite_p1 <= 1'b0;
      memread_p1  <= 1'b0;
      useimm_p1   <= 1'b0;
      aluop_p1    <= '0;
      rs_p1       <= '0;
      rt_p1       <= '0;
      rd_p1       <= '0;
      rsdata_p1   <= '0;
      rtdata_p1   <= '0;
      imm_p1      <= '0;
    end else if (!Stall) begin
      if (HazardStall) begin
        vld_p1      <= 1'b0;
        regwrite_p1 <= 1'b0;
        memread_p1  <= 1'b0;
        useimm_p1   <= 1'b0;
        aluop_p1    <= '0;
        rs_p1       <= '0;
        rt_p1       <= '0;
        rd_p1       <= '0;
        rsdata_p1   <= '0;
        rtdata_p1   <= '0;
        imm_p1      <= '0;
      end else begin
        vld_p1      <= InValid;
        regwrite_p1 <= RegWrite;
        memread_p1  <= MemRead;
        useimm_p1   <= UseImm;
        aluop_p1    <= AluOp;
        rs_p1       <= Rs;
        rt_p1       <= Rt;
        rd_p1       <= Rd;
        rsdata_p1   <= RsData;
        rtdata_p1   <= RtData;
        imm_p1      <= Imm;
      end
    end
  end

  // ---- EX operand selection (combinational on p1) ----
  always_comb begin
    fwd_rs = fwd_sel(rs_p1, rsdata_p1, ExMemRegWrite, ExMemRd, ExMemResult,
                     MemWbRegWrite, MemWbRd, MemWbResult);
    fwd_rt = fwd_sel(rt_p1, rtdata_p1, ExMemRegWrite, ExMemRd, ExMemResult,
                     MemWbRegWrite, MemWbRd, MemWbResult);
  end

  assign Data1      = fwd_rs;
  assign Data2      = useimm_p1 ? imm_p1 : fwd_rt;
  assign StoreData  = fwd_rt;
  assign Control    = aluop_p1;
  assign ExRd       = rd_p1;
  assign ExValid    = vld_p1;
  assign ExRegWrite = regwrite_p1 && vld_p1;
  assign ExMemRead  = memread_p1 && vld_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 4;

  typedef struct {
    bit               rst, stall, flush, inv, useimm, rw, mr, emw, mww;
    logic [WIDTH-1:0] rsd, rtd, imm, emres, mwres;
    logic [3:0]       op;
    logic [4:0]       rs, rt, rd, emrd, mwrd;
  } stim_t;

  // What instruction currently occupies the EX slot (empty slot = all zero).
  typedef struct {
    bit               valid, rw, mr, useimm;
    logic [3:0]       op;
    logic [4:0]       rs, rt, rd;
    logic [WIDTH-1:0] rsd, rtd, imm;
  } slot_t;

  typedef struct {
    logic [WIDTH-1:0] d1, d2, sd;
    logic [3:0]       ctrl;
    logic [4:0]       exrd;
    bit               exrw, exmr, exv, hz;
  } exp_t;

  logic              Clock = 1'b0;
  logic              Reset, Stall, Flush, InValid, UseImm, RegWrite, MemRead;
  logic              ExMemRegWrite, MemWbRegWrite;
  logic [WIDTH-1:0]  RsData, RtData, Imm, ExMemResult, MemWbResult;
  logic [CTRL_W-1:0] AluOp;
  logic [REG_AW-1:0] Rs, Rt, Rd, ExMemRd, MemWbRd;
  logic [WIDTH-1:0]  Data1, Data2, StoreData;
  logic [CTRL_W-1:0] Control;
  logic [REG_AW-1:0] ExRd;
  logic              ExRegWrite, ExMemRead, ExValid, HazardStall;

  alu_operand_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
    .Clock(Clock), .Reset(Reset), .Stall(Stall), .Flush(Flush), .InValid(InValid),
    .RsData(RsData), .RtData(RtData), .Imm(Imm), .UseImm(UseImm), .AluOp(AluOp),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .RegWrite(RegWrite), .MemRead(MemRead),
    .ExMemRegWrite(ExMemRegWrite), .ExMemRd(ExMemRd), .ExMemResult(ExMemResult),
    .MemWbRegWrite(MemWbRegWrite), .MemWbRd(MemWbRd), .MemWbResult(MemWbResult),
    .Data1(Data1), .Data2(Data2), .Control(Control), .StoreData(StoreData),
    .ExRd(ExRd), .ExRegWrite(ExRegWrite), .ExMemRead(ExMemRead),
    .ExValid(ExValid), .HazardStall(HazardStall)
  );

  always #5 Clock = ~Clock;

  exp_t  expq[$];
  slot_t ex;
  int    tests = 0;
  int    failed = 0;
  int    cyc = 0;

  // Value of a source register as the ALU must see it: the newest in-flight
  // writer of that register supplies it; r0 always reads from the file.
  function automatic logic [WIDTH-1:0] operand(input logic [4:0] src,
                                               input logic [WIDTH-1:0] fileval,
                                               input stim_t s);
    bit               we  [2];
    logic [4:0]       dst [2];
    logic [WIDTH-1:0] val [2];
    we[0] = s.emw; dst[0] = s.emrd; val[0] = s.emres;   // youngest first
    we[1] = s.mww; dst[1] = s.mwrd; val[1] = s.mwres;
    if (src == 0) return fileval;
    for (int i = 0; i < 2; i++)
      if (we[i] && dst[i] == src) return val[i];
    return fileval;
  endfunction

  function automatic bit load_use(input slot_t e, input stim_t s);
    return e.valid && e.mr && e.rt != 0 && s.inv && (e.rt == s.rs || e.rt == s.rt);
  endfunction

  function automatic exp_t expect_of(input slot_t e, input stim_t s);
    exp_t r;
    logic [WIDTH-1:0] rtv;
    rtv    = operand(e.rt, e.rtd, s);
    r.d1   = operand(e.rs, e.rsd, s);
    r.d2   = e.useimm ? e.imm : rtv;
    r.sd   = rtv;
    r.ctrl = e.op;
    r.exrd = e.rd;
    r.exv  = e.valid;
    r.exrw = e.valid && e.rw;
    r.exmr = e.valid && e.mr;
    r.hz   = load_use(e, s);
    return r;
  endfunction

  function automatic slot_t empty_slot();
    slot_t z;
    z = '{default: '0};
    return z;
  endfunction

  function automatic slot_t next_slot(input slot_t e, input stim_t s);
    slot_t n;
    if (s.rst || s.flush) return empty_slot();
    if (s.stall) return e;
    if (load_use(e, s)) return empty_slot();
    n.valid = s.inv; n.rw = s.rw; n.mr = s.mr; n.useimm = s.useimm;
    n.op = s.op; n.rs = s.rs; n.rt = s.rt; n.rd = s.rd;
    n.rsd = s.rsd; n.rtd = s.rtd; n.imm = s.imm;
    return n;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    Reset = s.rst; Stall = s.stall; Flush = s.flush; InValid = s.inv;
    RsData = s.rsd; RtData = s.rtd; Imm = s.imm; UseImm = s.useimm;
    AluOp = s.op; Rs = s.rs; Rt = s.rt; Rd = s.rd;
    RegWrite = s.rw; MemRead = s.mr;
    ExMemRegWrite = s.emw; ExMemRd = s.emrd; ExMemResult = s.emres;
    MemWbRegWrite = s.mww; MemWbRd = s.mwrd; MemWbResult = s.mwres;
  endtask

  // One cycle: apply inputs, queue the expected outputs, advance the model.
  task automatic step(input stim_t s);
    drive(s);
    expq.push_back(expect_of(ex, s));
    @(posedge Clock);
    ex = next_slot(ex, s);
    #1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    logic [3:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101, 4'b1110};
    s.rst    = ($urandom_range(0, 99) < 2);
    s.flush  = ($urandom_range(0, 99) < 8);
    s.stall  = ($urandom_range(0, 99) < 15);
    s.inv    = ($urandom_range(0, 99) < 85);
    s.useimm = $urandom_range(0, 1);
    s.rw     = $urandom_range(0, 1);
    s.mr     = ($urandom_range(0, 99) < 30);
    s.emw    = $urandom_range(0, 1);
    s.mww    = $urandom_range(0, 1);
    s.rsd = $urandom; s.rtd = $urandom; s.imm = $urandom;
    s.emres = $urandom; s.mwres = $urandom;
    s.op = ops[$urandom_range(0, 7)];
    s.rs = 5'($urandom_range(0, 4)); s.rt = 5'($urandom_range(0, 4));
    s.rd = 5'($urandom_range(0, 4)); s.emrd = 5'($urandom_range(0, 4));
    s.mwrd = 5'($urandom_range(0, 4));
    return s;
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  // Monitor: the stage always presents outputs, so every cycle is checked.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      cyc++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("ExValid",     32'(ExValid),     32'(e.exv));
        chk("HazardStall", 32'(HazardStall), 32'(e.hz));
        chk("ExRegWrite",  32'(ExRegWrite),  32'(e.exrw));
        chk("ExMemRead",   32'(ExMemRead),   32'(e.exmr));
        chk("Control",     32'(Control),     32'(e.ctrl));
        chk("ExRd",        32'(ExRd),        32'(e.exrd));
        chk("Data1",       Data1,            e.d1);
        chk("Data2",       Data2,            e.d2);
        chk("StoreData",   StoreData,        e.sd);
      end
    end
  end

  initial begin
    stim_t s, prod;
    s = idle(); s.rst = 1'b1;
    drive(s);
    @(posedge Clock);
    ex = empty_slot();
    #1;

    // Reset held two cycles while the other inputs toggle.
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.rst = 1'b1; step(s);
    end

    // add r3,r1,r2 with no forwarding; observe next cycle.
    s = idle(); s.inv = 1; s.rw = 1; s.op = 4'b0010;
    s.rs = 1; s.rt = 2; s.rd = 3; s.rsd = 5; s.rtd = 7;
    step(s);
    step(idle());

    // Forwarding priority on Rs=1, held in EX by Stall.
    s = idle(); s.inv = 1; s.rw = 1; s.op = 4'b0110; s.rs = 1; s.rt = 2;
    s.rsd = 32'h11; s.rtd = 32'h22;
    step(s);
    prod = idle(); prod.stall = 1;
    prod.emw = 1; prod.emrd = 1; prod.emres = 32'hAA;
    prod.mww = 1; prod.mwrd = 1; prod.mwres = 32'hBB;
    step(prod);
    prod.emw = 0;
    step(prod);
    s = idle(); s.inv = 1; s.rs = 0; s.rsd = 32'h55;
    step(s);
    prod = idle(); prod.emw = 1; prod.emrd = 0; prod.emres = 32'hAA;
    prod.mww = 1; prod.mwrd = 0; prod.mwres = 32'hBB;
    step(prod);

    // lw r4 followed by a consumer of r4.
    s = idle(); s.inv = 1; s.rw = 1; s.mr = 1; s.rt = 4; s.rd = 4; s.rs = 2;
    step(s);
    s = idle(); s.inv = 1; s.rw = 1; s.op = 4'b0010; s.rs = 4; s.rt = 1; s.rd = 5;
    s.rsd = 32'h1; s.rtd = 32'h2;
    step(s);                      // hazard, bubble enters
    step(s);                      // consumer loads
    prod = idle(); prod.mww = 1; prod.mwrd = 4; prod.mwres = 32'h1234_5678;
    step(prod);

    // Stall 3 cycles with new ID inputs, then Flush with Stall.
    s = idle(); s.inv = 1; s.rw = 1; s.op = 4'b1101; s.rs = 3; s.rt = 2; s.rd = 1;
    s.rsd = 32'hDEAD; s.rtd = 32'hBEEF;
    step(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.rst = 0; s.flush = 0; s.stall = 1; step(s);
    end
    s = rand_stim(); s.rst = 0; s.flush = 1; s.stall = 1; step(s);
    step(idle());

    // Immediate select with forwarded Rt for the store path.
    s = idle(); s.inv = 1; s.useimm = 1; s.imm = 32'hFFFF_FFFC; s.rt = 2;
    s.rtd = 32'h99; s.rs = 0; s.op = 4'b0010;
    step(s);
    prod = idle(); prod.emw = 1; prod.emrd = 2; prod.emres = 32'h10;
    step(prod);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) step(rand_stim());

    @(negedge Clock);
    #1;
    if (expq.size() != 0) begin
      tests++; failed++;
      $display("FAIL drain: %0d expected responses left, required 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
